// File: rtl/hazard_ctrl_v2_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
// FSM states and stall-cause codes are plain constants to stay compatible with older tooling.
package hazard_pkg;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t ST_RUN      = 2'd0;
  localparam hz_state_t ST_LD_STALL = 2'd1;
  localparam hz_state_t ST_MD_WAIT  = 2'd2;

  typedef logic [2:0] stall_cause_t;

  localparam stall_cause_t CAUSE_NONE     = 3'd0;
  localparam stall_cause_t CAUSE_DMEM     = 3'd1;
  localparam stall_cause_t CAUSE_MD       = 3'd2;
  localparam stall_cause_t CAUSE_REDIRECT = 3'd3;
  localparam stall_cause_t CAUSE_LOAD     = 3'd4;
  localparam stall_cause_t CAUSE_IMEM     = 3'd5;

endpackage

// File: rtl/hazard_ctrl_v2_if.sv
// Bundle between the pipeline (master) and the stall/flush controller (slave).
interface hazard_ctrl_v2_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_ex_mem_read;
  logic [REG_AW-1:0] id_ex_rd;
  logic              id_ex_is_md;
  logic              md_done;
  logic              branch;
  logic              ex_jump;
  logic              icache_stall;
  logic              dcache_stall;
  logic              perf_clr;

  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              md_start;
  logic [2:0]        stall_cause;
  logic [CNT_W-1:0]  cnt_dmem;
  logic [CNT_W-1:0]  cnt_md;
  logic [CNT_W-1:0]  cnt_redirect;
  logic [CNT_W-1:0]  cnt_load;
  logic [CNT_W-1:0]  cnt_imem;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_mem_read, id_ex_rd,
           id_ex_is_md, md_done, branch, ex_jump, icache_stall, dcache_stall, perf_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start, stall_cause,
           cnt_dmem, cnt_md, cnt_redirect, cnt_load, cnt_imem
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_mem_read, id_ex_rd,
           id_ex_is_md, md_done, branch, ex_jump, icache_stall, dcache_stall, perf_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start, stall_cause,
           cnt_dmem, cnt_md, cnt_redirect, cnt_load, cnt_imem
  );

endinterface

// File: rtl/hazard_ctrl_v2_sat_counter.sv
// Saturating up-counter with synchronous clear, used for per-cause stall statistics.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_v2.sv
// Pipeline stall/flush controller: prioritises memory freezes, MUL/DIV waits, redirects,
// load-use bubbles and fetch stalls, and keeps a saturating cycle count per stall cause.
module hazard_ctrl_v2 #(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_v2_if.slave hz
);

  import hazard_pkg::*;

  localparam logic [1:0] LD_RELOAD = 2'(LOAD_USE_CYCLES - 1);

  hz_state_t         state;
  hz_state_t         next_state;
  logic [1:0]        ld_cnt;
  logic [1:0]        next_ld_cnt;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              redirect;
  logic              load_hz;
  logic              md_busy;
  stall_cause_t      cause;

  assign rs1      = hz.id_rs1;
  assign rs2      = hz.id_rs2;
  assign ex_rd    = hz.id_ex_rd;
  assign redirect = hz.branch | hz.ex_jump;
  assign load_hz  = hz.id_ex_mem_read && (ex_rd != '0) &&
                    ((hz.id_use_rs1 && (rs1 == ex_rd)) ||
                     (hz.id_use_rs2 && (rs2 == ex_rd)));

  // md_done arriving in the start cycle is ignored, so the start cycle is always busy.
  assign md_busy = ((state == ST_RUN) && hz.id_ex_is_md) ||
                   ((state == ST_MD_WAIT) && !hz.md_done);

  always_comb begin
    next_state      = state;
    next_ld_cnt     = ld_cnt;
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.id_ex_en     = 1'b1;
    hz.ex_mem_en    = 1'b1;
    hz.mem_wb_en    = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.md_start     = 1'b0;
    cause           = CAUSE_NONE;

    if (!rst_n) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
      next_state      = ST_RUN;
      next_ld_cnt     = '0;
    end else if (hz.dcache_stall) begin
      // Freeze everything upstream of MEM/WB; a pending redirect simply waits its turn.
      hz.pc_en     = 1'b0;
      hz.if_id_en  = 1'b0;
      hz.id_ex_en  = 1'b0;
      hz.ex_mem_en = 1'b0;
      cause        = CAUSE_DMEM;
    end else if (md_busy) begin
      hz.pc_en        = 1'b0;
      hz.if_id_en     = 1'b0;
      hz.id_ex_en     = 1'b0;
      hz.ex_mem_flush = 1'b1;
      cause           = CAUSE_MD;
      if (state == ST_RUN) begin
        hz.md_start = 1'b1;
        next_state  = ST_MD_WAIT;
      end
    end else begin
      if (state == ST_MD_WAIT) begin
        next_state = ST_RUN;
      end

      if (redirect) begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
        next_ld_cnt    = '0;
        next_state     = ST_RUN;
        cause          = CAUSE_REDIRECT;
      end else if (state == ST_LD_STALL) begin
        hz.pc_en       = 1'b0;
        hz.if_id_en    = 1'b0;
        hz.id_ex_flush = 1'b1;
        cause          = CAUSE_LOAD;
        next_ld_cnt    = ld_cnt - 2'd1;
        if (ld_cnt <= 2'd1) begin
          next_ld_cnt = '0;
          next_state  = ST_RUN;
        end
      end else if (load_hz) begin
        hz.pc_en       = 1'b0;
        hz.if_id_en    = 1'b0;
        hz.id_ex_flush = 1'b1;
        cause          = CAUSE_LOAD;
        if (LOAD_USE_CYCLES > 1) begin
          next_ld_cnt = LD_RELOAD;
          next_state  = ST_LD_STALL;
        end
      end else if (hz.icache_stall) begin
        hz.pc_en       = 1'b0;
        hz.if_id_en    = 1'b0;
        hz.id_ex_flush = 1'b1;
        cause          = CAUSE_IMEM;
      end
    end
  end

  assign hz.stall_cause = cause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      ld_cnt <= '0;
    end else begin
      state  <= next_state;
      ld_cnt <= next_ld_cnt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_dmem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.perf_clr),
    .inc   (cause == CAUSE_DMEM),
    .q     (hz.cnt_dmem)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_md (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.perf_clr),
    .inc   (cause == CAUSE_MD),
    .q     (hz.cnt_md)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_redirect (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.perf_clr),
    .inc   (cause == CAUSE_REDIRECT),
    .q     (hz.cnt_redirect)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_load (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.perf_clr),
    .inc   (cause == CAUSE_LOAD),
    .q     (hz.cnt_load)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_imem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.perf_clr),
    .inc   (cause == CAUSE_IMEM),
    .q     (hz.cnt_imem)
  );

endmodule
